// File: rtl/nrisc_pkg.sv
// Shared types and constants for the Nrisc instruction-fetch slice.
package nrisc_pkg;

  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned INSTR_W = 8;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [INSTR_W-1:0] instr_t;

  localparam instr_t HALT_INSTR = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/nrisc_pc.sv
// Program counter: load (redirect/restart) has priority over increment; wraps modulo 2^ADDR_W.
module nrisc_pc
  import nrisc_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_pc,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_pc;
    end else if (inc) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/nrisc_fetch_ctrl.sv
// Instruction-fetch sequencer: drives instruction-memory address, captures the returned word
// and presents it to decode over valid/ready, with redirect, wrap-around and halt handling.
module nrisc_fetch_ctrl
  import nrisc_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_data,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               halted,
  output logic [7:0]         fetch_count
);

  localparam int unsigned       WAIT_W    = 2;
  localparam int unsigned       CNT_W     = 8;
  // MEM_LAT is legal in 1..3, so the last wait value fits in WAIT_W bits.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  fetch_state_e       state, state_nxt;
  logic [WAIT_W-1:0]  wait_cnt, wait_cnt_nxt;
  logic [ADDR_W-1:0]  mem_addr_nxt;
  logic [INSTR_W-1:0] instr_nxt;
  logic [ADDR_W-1:0]  instr_pc_nxt;
  logic               instr_valid_nxt;
  logic               halted_nxt;
  logic [CNT_W-1:0]   fetch_count_nxt;

  logic               pc_load;
  logic               pc_inc;
  logic [ADDR_W-1:0]  pc_load_val;
  logic [ADDR_W-1:0]  pc;

  logic               handshake;
  logic               mem_ready;
  logic               is_halt;

  assign handshake = instr_valid & instr_ready;
  assign mem_ready = (wait_cnt == WAIT_LAST);
  assign is_halt   = (instr == HALT_INSTR);

  nrisc_pc u_pc (
    .clock   (clock),
    .reset   (reset),
    .load    (pc_load),
    .load_pc (pc_load_val),
    .inc     (pc_inc),
    .pc      (pc)
  );

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      mem_addr    <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      mem_addr    <= mem_addr_nxt;
      instr       <= instr_nxt;
      instr_pc    <= instr_pc_nxt;
      instr_valid <= instr_valid_nxt;
      halted      <= halted_nxt;
      fetch_count <= fetch_count_nxt;
    end
  end

  // Next-state logic; redirect dominates start in IDLE and aborts any fetch in flight.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!redirect && start) state_nxt = FETCH;
      end
      FETCH: begin
        if (!redirect && mem_ready) state_nxt = HOLD;
      end
      HOLD: begin
        if (redirect) begin
          state_nxt = FETCH;
        end else if (instr_ready) begin
          state_nxt = is_halt ? HALT : FETCH;
        end
      end
      HALT: begin
        if (start) state_nxt = FETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath next values; a consumed instruction is counted even when a redirect lands with it.
  always_comb begin
    mem_addr_nxt    = mem_addr;
    instr_nxt       = instr;
    instr_pc_nxt    = instr_pc;
    instr_valid_nxt = instr_valid;
    halted_nxt      = halted;
    wait_cnt_nxt    = wait_cnt;
    pc_load         = 1'b0;
    pc_load_val     = redirect_pc;
    pc_inc          = 1'b0;
    fetch_count_nxt = (handshake && (fetch_count != CNT_MAX)) ? fetch_count + CNT_W'(1)
                                                              : fetch_count;
    case (state)
      IDLE: begin
        if (redirect) begin
          pc_load = 1'b1;
        end else if (start) begin
          mem_addr_nxt = pc;
          wait_cnt_nxt = '0;
        end
      end
      FETCH: begin
        if (redirect) begin
          pc_load      = 1'b1;
          mem_addr_nxt = redirect_pc;
          wait_cnt_nxt = '0;
        end else if (mem_ready) begin
          // pc tracks mem_addr while fetching, so the increment yields mem_addr+1.
          instr_nxt       = mem_data;
          instr_pc_nxt    = mem_addr;
          instr_valid_nxt = 1'b1;
          pc_inc          = 1'b1;
          wait_cnt_nxt    = '0;
        end else begin
          wait_cnt_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      HOLD: begin
        if (redirect) begin
          instr_valid_nxt = 1'b0;
          pc_load         = 1'b1;
          mem_addr_nxt    = redirect_pc;
          wait_cnt_nxt    = '0;
        end else if (instr_ready) begin
          instr_valid_nxt = 1'b0;
          if (is_halt) begin
            halted_nxt = 1'b1;
          end else begin
            mem_addr_nxt = pc;
            wait_cnt_nxt = '0;
          end
        end
      end
      HALT: begin
        if (start) begin
          pc_load      = 1'b1;
          pc_load_val  = '0;
          mem_addr_nxt = '0;
          halted_nxt   = 1'b0;
          wait_cnt_nxt = '0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_nrisc_fetch_ctrl.sv
// Bench for nrisc_fetch_ctrl: directed scenarios plus random traffic against a transaction model.
module tb_nrisc_fetch_ctrl;

  logic       clock;
  logic       reset;
  logic       start;
  logic [3:0] mem_addr;
  logic [7:0] mem_data;
  logic [7:0] instr;
  logic [3:0] instr_pc;
  logic       instr_valid;
  logic       instr_ready;
  logic       redirect;
  logic [3:0] redirect_pc;
  logic       halted;
  logic [7:0] fetch_count;

  nrisc_fetch_ctrl #(.MEM_LAT(1)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Instruction memory, read on the falling edge.
  logic [7:0] mem [16];
  always @(negedge clock) mem_data <= mem[mem_addr];

  int vectors     = 0;
  int miscompares = 0;
  logic [11:0] hs_log [$];

  // Reference model state: what decode should see, in transaction terms.
  logic       m_active, m_halted, m_valid;
  logic [3:0] m_pc, m_fetch, m_ipc;
  logic [7:0] m_instr, m_count;
  int         m_left;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_halted = 1'b0; m_valid = 1'b0;
    m_pc = 4'd0; m_fetch = 4'd0; m_ipc = 4'd0;
    m_instr = 8'd0; m_count = 8'd0; m_left = 0;
  endtask

  task automatic begin_fetch(input logic [3:0] a);
    m_active = 1'b1; m_fetch = a; m_pc = a; m_left = 1;
  endtask

  task automatic model_step(input logic st, input logic rd, input logic [3:0] rpc, input logic rdy);
    if (m_valid && rdy && m_count != 8'd255) m_count = m_count + 8'd1;
    if (m_halted) begin
      if (st) begin m_halted = 1'b0; begin_fetch(4'd0); end
    end else if (!m_active) begin
      if (rd) m_pc = rpc;
      else if (st) begin_fetch(m_pc);
    end else if (rd) begin
      m_valid = 1'b0;
      begin_fetch(rpc);
    end else if (m_valid) begin
      if (rdy) begin
        m_valid = 1'b0;
        if (m_instr == 8'hFF) begin m_halted = 1'b1; m_active = 1'b0; end
        else begin_fetch(m_pc);
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_valid = 1'b1; m_instr = mem[m_fetch]; m_ipc = m_fetch; m_pc = m_fetch + 4'd1;
      end
    end
  endtask

  task automatic compare_all();
    chk("valid", 32'(instr_valid), 32'(m_valid));
    chk("instr", 32'(instr), 32'(m_instr));
    chk("instr_pc", 32'(instr_pc), 32'(m_ipc));
    chk("halted", 32'(halted), 32'(m_halted));
    chk("fetch_count", 32'(fetch_count), 32'(m_count));
    chk("mem_addr", 32'(mem_addr), 32'(m_fetch));
  endtask

  // One clock: drive after negedge, model at posedge, check 1 ns later.
  task automatic cycle(input logic st, input logic rd, input logic [3:0] rpc, input logic rdy);
    start = st; redirect = rd; redirect_pc = rpc; instr_ready = rdy;
    if (instr_valid && rdy) hs_log.push_back({instr_pc, instr});
    @(posedge clock);
    model_step(st, rd, rpc, rdy);
    #1 compare_all();
    @(negedge clock);
  endtask

  task automatic run(input int n, input logic rdy);
    repeat (n) cycle(1'b0, 1'b0, 4'd0, rdy);
  endtask

  // Reset asserted mid-cycle: outputs must clear before the next clock edge.
  task automatic do_reset();
    start = 1'b0; redirect = 1'b0; redirect_pc = 4'd0; instr_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_instr_pc", 32'(instr_pc), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_count", 32'(fetch_count), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    hs_log.delete();
  endtask

  task automatic chk_log(input string tag, input int idx, input logic [11:0] exp);
    logic [11:0] got;
    got = 'x;
    if (idx < hs_log.size()) got = hs_log[idx];
    chk(tag, 32'(got), 32'(exp));
  endtask

  task automatic base_mem();
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[0] = 8'h01; mem[1] = 8'h0F; mem[2] = 8'h05; mem[3] = 8'hFF; mem[9] = 8'h42;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; redirect = 1'b0; redirect_pc = 4'd0; instr_ready = 1'b0;
    base_mem();
    model_reset();
    @(negedge clock);
    do_reset();

    // Straight-line program ending in halt, consumer always ready.
    cycle(1'b1, 1'b0, 4'd0, 1'b1);
    run(10, 1'b1);
    chk_log("seq0", 0, 12'h001);
    chk_log("seq1", 1, 12'h10F);
    chk_log("seq2", 2, 12'h205);
    chk_log("seq3", 3, 12'h3FF);
    chk("seq_halted", 32'(halted), 32'd1);
    chk("seq_count", 32'(fetch_count), 32'd4);
    chk("seq_valid", 32'(instr_valid), 32'd0);

    // Restart from HALT resumes at address 0.
    cycle(1'b1, 1'b0, 4'd0, 1'b1);
    chk("restart_halted", 32'(halted), 32'd0);
    run(2, 1'b1);
    chk_log("restart0", 4, 12'h001);

    // Back-pressure: decode stalls for 5 cycles after the first valid.
    do_reset();
    cycle(1'b1, 1'b0, 4'd0, 1'b0);
    run(6, 1'b0);
    chk("stall_instr", 32'(instr), 32'h01);
    chk("stall_pc", 32'(instr_pc), 32'd0);
    chk("stall_addr", 32'(mem_addr), 32'd0);
    chk("stall_count", 32'(fetch_count), 32'd0);
    run(8, 1'b1);
    chk("stall_done_count", 32'(fetch_count), 32'd4);

    // Redirect during the fetch of address 0.
    do_reset();
    cycle(1'b1, 1'b0, 4'd0, 1'b1);
    cycle(1'b0, 1'b1, 4'd2, 1'b1);
    run(5, 1'b1);
    chk_log("rdfetch0", 0, 12'h205);
    chk_log("rdfetch1", 1, 12'h3FF);

    // Redirect in the same cycle as the handshake of (1,15).
    do_reset();
    cycle(1'b1, 1'b0, 4'd0, 1'b1);
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
        if (m_valid && m_ipc == 4'd1) begin
          cycle(1'b0, 1'b1, 4'd9, 1'b1);
          seen = 1'b1;
        end else begin
          cycle(1'b0, 1'b0, 4'd0, 1'b1);
        end
      end
      chk("rdhs_seen", 32'(seen), 32'd1);
    end
    chk("rdhs_count", 32'(fetch_count), 32'd2);
    run(3, 1'b1);
    chk_log("rdhs_next", 2, 12'h942);

    // Wrap from address 15 to 0.
    do_reset();
    mem[15] = 8'h07;
    cycle(1'b0, 1'b1, 4'd15, 1'b1);
    cycle(1'b1, 1'b0, 4'd0, 1'b1);
    run(12, 1'b1);
    chk_log("wrap0", 0, 12'hF07);
    chk_log("wrap1", 1, 12'h001);
    chk("wrap_count", 32'(fetch_count), 32'd5);

    // Reset while an instruction is held valid, then refetch from 0.
    do_reset();
    cycle(1'b1, 1'b0, 4'd0, 1'b0);
    cycle(1'b0, 1'b0, 4'd0, 1'b0);
    chk("pre_rst_valid", 32'(instr_valid), 32'd1);
    do_reset();
    cycle(1'b1, 1'b0, 4'd0, 1'b1);
    run(2, 1'b1);
    chk_log("post_rst0", 0, 12'h001);

    // Counter saturation with a halt-free memory.
    for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
    do_reset();
    cycle(1'b1, 1'b0, 4'd0, 1'b1);
    run(560, 1'b1);
    chk("sat_count", 32'(fetch_count), 32'd255);

    // Random traffic.
    for (int seg = 0; seg < 4; seg++) begin
      for (int i = 0; i < 16; i++) begin
        mem[i] = 8'($urandom);
        if ($urandom_range(0, 9) == 0) mem[i] = 8'hFF;
      end
      do_reset();
      for (int c = 0; c < 200; c++) begin
        cycle(($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
              4'($urandom_range(0, 15)), ($urandom_range(0, 2) != 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nrisc_fetch_ctrl.md
Name: nrisc_fetch_ctrl

Overview:
Instruction-fetch sequencer for the Nrisc processor. It owns the program counter and drives the address of the 16-word × 8-bit instruction memory. It captures each returned word and presents it to decode over a valid/ready handshake. It also handles jump redirects, PC wrap-around, and halt on a designated halt instruction.

Parameters:
ADDR_W, 4, instruction memory address width (16 words)
INSTR_W, 8, instruction word width
MEM_LAT, 1, posedges from mem_addr change to mem_data valid (memory reads on negedge); legal range 1..3
HALT_INSTR, 8'hFF, instruction encoding that halts fetch

Ports:
clock  input  1  system clock; all state on posedge
reset  input  1  asynchronous, active-high reset
start  input  1  begin fetching (IDLE) / restart from address 0 (HALT)
mem_addr  output  ADDR_W  address to instruction memory
mem_data  input  INSTR_W  instruction memory read data
instr  output  INSTR_W  fetched instruction to decode
instr_pc  output  ADDR_W  address instr was fetched from
instr_valid  output  1  instr/instr_pc valid
instr_ready  input  1  decode accepts instr
redirect  input  1  jump request, single-cycle sampled
redirect_pc  input  ADDR_W  jump target
halted  output  1  fetch stopped on HALT_INSTR
fetch_count  output  8  instructions consumed, saturating

Behaviour:
- Reset (async, any state): state=IDLE, pc=0, mem_addr=0, instr=0, instr_pc=0, instr_valid=0, halted=0, fetch_count=0, wait counter=0. Release mid-fetch leaves no residue.
- States: IDLE, FETCH, HOLD, HALT.
- IDLE:
  - start=1 → FETCH, mem_addr=pc, wait=0.
  - redirect=1 loads pc=redirect_pc and stays IDLE.
  - redirect wins over start if both are asserted.
- FETCH:
  - wait counts posedges.
  - At the MEM_LAT-th posedge after entry: instr<=mem_data, instr_pc<=mem_addr, pc<=mem_addr+1 (mod 16, 15→0 wraps silently), instr_valid<=1 → HOLD.
- HOLD:
  - instr, instr_pc and instr_valid are held stable while instr_ready=0.
  - On a posedge with instr_valid&instr_ready: fetch_count++ (saturates at 255).
  - If instr==HALT_INSTR: instr_valid<=0, halted<=1 → HALT.
  - Otherwise: instr_valid<=0, mem_addr<=pc → FETCH.
- HALT:
  - halted=1, instr_valid=0, mem_addr holds.
  - start=1 → pc=0, mem_addr=0, halted<=0 → FETCH.
  - redirect is ignored.
- Redirect in FETCH or HOLD:
  - Abort the current fetch: instr_valid<=0, pc<=redirect_pc, mem_addr<=redirect_pc, wait<=0 → FETCH.
  - Same-cycle valid&ready&redirect: the presented instruction counts as consumed (fetch_count++), then the redirect applies.
  - A HALT_INSTR consumed in that cycle does not halt; redirect has priority.
- Latency:
  - start at edge E0 → instr_valid high after edge E0+MEM_LAT.
  - Handshake at Eh → next instr_valid after Eh+MEM_LAT.
  - Throughput with a ready-always consumer: 1 instruction per MEM_LAT+1 cycles.
- mem_addr changes only on posedge, so it is stable across the memory's negedge read.
- instr_ready is ignored when instr_valid=0.

Decomposition:
- Shared package nrisc_pkg holds:
  - ADDR_W, INSTR_W, HALT_INSTR constants
  - fetch state enum (IDLE, FETCH, HOLD, HALT)
  - addr_t and instr_t typedefs
- One natural sub-module, nrisc_pc: PC register with load (redirect/restart), increment-with-wrap and hold.
- FSM, wait counter and output registers stay in nrisc_fetch_ctrl.

Test Plan:
- Memory preloaded {0:1, 1:15, 2:5, 3:8'hFF}, instr_ready=1, pulse start → decode sees (pc,instr) = (0,1), (1,15), (2,5), (3,FF) at 2-cycle spacing; then halted=1, fetch_count=4, instr_valid=0.
- Same memory, instr_ready=0 for 5 cycles after first valid → instr=1, instr_pc=0 held stable; mem_addr does not advance; fetch_count stays 0 until ready rises.
- redirect=1, redirect_pc=2 during FETCH of address 0 → address-0 word never presented; next valid is (2,5).
- Redirect asserted in the same cycle as a handshake of (1,15) → fetch_count increments; next valid is from redirect_pc.
- pc=15 fetch with mem[15]=7, mem[0]=1 → (15,7) then (0,1); no halt, no error.
- Assert reset while instr_valid=1 in HOLD → all outputs zero immediately (asynchronous, before next clock); after release, start refetches from address 0.
- From HALT, pulse start → halted drops and fetch resumes at address 0.
